// File: rtl/dest_pipe_pkg.sv
// Shared definitions for the destination-register pipeline: regdst encodings
// and the per-stage entry carried from ID to WB.
package dest_pipe_pkg;

   localparam int unsigned DP_ADDR_W_MAX = 8;

   localparam logic [1:0] RDST_RT   = 2'b00;
   localparam logic [1:0] RDST_RD   = 2'b01;
   localparam logic [1:0] RDST_LINK = 2'b10;
   localparam logic [1:0] RDST_NONE = 2'b11;

   // Address is stored zero-extended so one entry type serves any REG_ADDR_W <= DP_ADDR_W_MAX
   typedef struct packed {
      logic                     we;
      logic [DP_ADDR_W_MAX-1:0] addr;
   } dest_entry_t;

endpackage

// File: rtl/dest_match.sv
// Combinational priority matcher: returns 1 + index of the youngest stage
// writing the queried register, or 0 when none does (query 0 never matches).
module dest_match
   import dest_pipe_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned IDX_W      = $clog2(STAGES + 1)
) (
   input  logic [REG_ADDR_W-1:0] query_i,
   input  dest_entry_t           stages_i [STAGES],
   output logic [IDX_W-1:0]      idx_o
);

   logic [DP_ADDR_W_MAX-1:0] query_ext;

   // Scan oldest to youngest so the youngest hit is the last assignment
   always_comb begin
      idx_o     = '0;
      query_ext = DP_ADDR_W_MAX'(query_i);
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (query_ext != '0 && stages_i[k].we && stages_i[k].addr == query_ext) begin
            idx_o = IDX_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/dest_reg_pipe.sv
// Destination-register decode and ID..WB pipeline with forwarding match indices.
// Optional RSEL_LINK_EN: regdst=10 selects LINK_REG; otherwise it means no write.
module dest_reg_pipe
   import dest_pipe_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned LINK_REG   = 31,
   parameter int unsigned IDX_W      = $clog2(STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_regwrite,
   input  logic [1:0]            id_regdst,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [REG_ADDR_W-1:0] id_rs_q,
   input  logic [REG_ADDR_W-1:0] id_rt_q,
   input  logic                  hold,
   input  logic                  bubble,
   output logic                  wb_we,
   output logic [REG_ADDR_W-1:0] wb_reg,
   output logic [IDX_W-1:0]      rs_match,
   output logic [IDX_W-1:0]      rt_match
);

`ifdef RSEL_LINK_EN
   localparam logic LINK_EN = 1'b1;
`else
   localparam logic LINK_EN = 1'b0;
`endif

   localparam logic [REG_ADDR_W-1:0] LINK_ADDR = REG_ADDR_W'(LINK_REG);

   logic [REG_ADDR_W-1:0] dest_c;
   logic                  writable_c;
   dest_entry_t           dec_c;
   dest_entry_t           stage_q [STAGES];
   dest_entry_t           stage_d [STAGES];

   // ID decode: pick destination and squash writes to register 0
   always_comb begin
      dest_c     = '0;
      writable_c = 1'b0;
      unique case (id_regdst)
         RDST_RT: begin
            dest_c     = id_rt;
            writable_c = 1'b1;
         end
         RDST_RD: begin
            dest_c     = id_rd;
            writable_c = 1'b1;
         end
         RDST_LINK: begin
            dest_c     = LINK_EN ? LINK_ADDR : '0;
            writable_c = LINK_EN;
         end
         default: begin
            dest_c     = '0;
            writable_c = 1'b0;
         end
      endcase
      dec_c.we   = id_valid & id_regwrite & writable_c & (dest_c != '0);
      dec_c.addr = DP_ADDR_W_MAX'(dest_c);
   end

   // Advance unless held; stage 0 takes a NOP on bubble or empty ID
   always_comb begin
      stage_d = stage_q;
      if (!hold) begin
         for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
         end
         stage_d[0] = (id_valid && !bubble) ? dec_c : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign wb_we  = stage_q[STAGES-1].we;
   assign wb_reg = stage_q[STAGES-1].addr[REG_ADDR_W-1:0];

   dest_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .STAGES     (STAGES),
      .IDX_W      (IDX_W)
   ) u_rs_match (
      .query_i  (id_rs_q),
      .stages_i (stage_q),
      .idx_o    (rs_match)
   );

   dest_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .STAGES     (STAGES),
      .IDX_W      (IDX_W)
   ) u_rt_match (
      .query_i  (id_rt_q),
      .stages_i (stage_q),
      .idx_o    (rt_match)
   );

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Bench for dest_reg_pipe: directed scenarios plus randomized traffic against
// a queue-based reference of in-flight register writes.
module tb_dest_reg_pipe;

   localparam int unsigned RW = 5;
   localparam int unsigned ST = 3;
   localparam int unsigned IW = $clog2(ST + 1);
   localparam int unsigned LINK = 31;

`ifdef RSEL_LINK_EN
   localparam bit LINK_ON = 1'b1;
`else
   localparam bit LINK_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, id_valid, id_regwrite, hold, bubble;
   logic [1:0]    id_regdst;
   logic [RW-1:0] id_rt, id_rd, id_rs_q, id_rt_q;
   logic          wb_we;
   logic [RW-1:0] wb_reg;
   logic [IW-1:0] rs_match, rt_match;

   always #5 clk = ~clk;

   dest_reg_pipe #(
      .REG_ADDR_W (RW),
      .STAGES     (ST),
      .LINK_REG   (LINK),
      .IDX_W      (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_regwrite (id_regwrite),
      .id_regdst   (id_regdst),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_rs_q     (id_rs_q),
      .id_rt_q     (id_rt_q),
      .hold        (hold),
      .bubble      (bubble),
      .wb_we       (wb_we),
      .wb_reg      (wb_reg),
      .rs_match    (rs_match),
      .rt_match    (rt_match)
   );

   // In-flight writes, youngest at index 0; known=0 means the address field is don't-care
   typedef struct {
      bit          we;
      int unsigned addr;
      bit          known;
   } ref_t;

   ref_t inflight[$];
   bit   ref_valid = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned ref_match(input int unsigned q);
      if (q == 0) return 0;
      foreach (inflight[i]) begin
         if (inflight[i].we && inflight[i].addr == q) return i + 1;
      end
      return 0;
   endfunction

   function automatic ref_t ref_decode(input bit v, input bit rw, input bit [1:0] rdst,
                                       input int unsigned rt, input int unsigned rd);
      ref_t e;
      int unsigned dst;
      bit wr;
      wr  = (rdst == 2'b00) || (rdst == 2'b01) || (rdst == 2'b10 && LINK_ON);
      dst = (rdst == 2'b00) ? rt : (rdst == 2'b01) ? rd : LINK;
      e.we    = v && rw && wr && dst != 0;
      e.addr  = e.we ? dst : 0;
      e.known = e.we || !v;
      return e;
   endfunction

   task automatic cyc(input bit rst, input bit v, input bit rw, input bit [1:0] rdst,
                      input int unsigned rt, input int unsigned rd,
                      input int unsigned rsq, input int unsigned rtq,
                      input bit hl, input bit bb);
      ref_t e;
      rst_n = rst; id_valid = v; id_regwrite = rw; id_regdst = rdst;
      id_rt = RW'(rt); id_rd = RW'(rd); id_rs_q = RW'(rsq); id_rt_q = RW'(rtq);
      hold = hl; bubble = bb;
      @(negedge clk);
      if (ref_valid) begin
         check("wb_we", 32'(wb_we), 32'(inflight[ST-1].we));
         if (inflight[ST-1].known) check("wb_reg", 32'(wb_reg), inflight[ST-1].addr);
         check("rs_match", 32'(rs_match), ref_match(rsq));
         check("rt_match", 32'(rt_match), ref_match(rtq));
      end
      if (!rst) begin
         inflight.delete();
         for (int i = 0; i < ST; i++) inflight.push_back('{we: 1'b0, addr: 0, known: 1'b1});
         ref_valid = 1'b1;
      end else if (ref_valid && !hl) begin
         e = (v && !bb) ? ref_decode(v, rw, rdst, rt, rd) : '{we: 1'b0, addr: 0, known: 1'b1};
         inflight.push_front(e);
         void'(inflight.pop_back());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned rsq, input int unsigned rtq);
      cyc(1, 0, 0, 2'b11, 0, 0, rsq, rtq, 0, 0);
   endtask

   initial begin
      // Reset with a live instruction on the ID inputs
      cyc(0, 1, 1, 2'b01, 0, 5, 5, 5, 0, 0);
      cyc(0, 1, 1, 2'b01, 0, 5, 5, 5, 0, 0);
      check("rst_wb_we", 32'(wb_we), 0);
      check("rst_wb_reg", 32'(wb_reg), 0);
      id_rs_q = RW'(5); #1;
      check("rst_rs_match", 32'(rs_match), 0);

      // Latency: rd=7 reaches WB after three edges, match index walks 1..3
      cyc(1, 1, 1, 2'b01, 0, 7, 7, 0, 0, 0);
      check("lat_idx1", 32'(rs_match), 1);
      idle(7, 0);
      check("lat_idx2", 32'(rs_match), 2);
      idle(7, 0);
      check("lat_we", 32'(wb_we), 1);
      check("lat_reg", 32'(wb_reg), 7);
      check("lat_idx3", 32'(rs_match), 3);
      idle(7, 0);
      check("lat_we_gone", 32'(wb_we), 0);

      // Priority: youngest writer of r9 wins
      cyc(1, 1, 1, 2'b01, 0, 9, 0, 9, 0, 0);
      cyc(1, 1, 1, 2'b00, 9, 0, 0, 9, 0, 0);
      check("prio_rt_match", 32'(rt_match), 1);
      idle(0, 9);

      // Register 0 squash
      cyc(1, 1, 1, 2'b00, 0, 3, 0, 0, 0, 0);
      idle(0, 0);
      idle(0, 0);
      check("r0_wb_we", 32'(wb_we), 0);
      check("r0_rs_match", 32'(rs_match), 0);

      // Hold beats bubble; entry frozen in stage 0
      cyc(1, 1, 1, 2'b01, 0, 4, 4, 0, 0, 0);
      cyc(1, 1, 1, 2'b01, 0, 6, 4, 0, 1, 1);
      check("hold_idx_a", 32'(rs_match), 1);
      cyc(1, 1, 1, 2'b01, 0, 6, 4, 0, 1, 1);
      check("hold_idx_b", 32'(rs_match), 1);
      idle(4, 0);
      idle(4, 0);
      check("hold_wb_reg", 32'(wb_reg), 4);
      check("hold_wb_we", 32'(wb_we), 1);

      // Link destination
      cyc(1, 1, 1, 2'b10, 0, 0, LINK, 0, 0, 0);
      idle(LINK, 0);
      idle(LINK, 0);
      check("link_wb_we", 32'(wb_we), 32'(LINK_ON));
      if (LINK_ON) check("link_wb_reg", 32'(wb_reg), LINK);

      // Randomized traffic, small register range to provoke matches
      for (int n = 0; n < 1500; n++) begin
         cyc(($urandom_range(63) != 0), ($urandom_range(3) != 0), ($urandom_range(4) != 0),
             2'($urandom_range(3)), $urandom_range(7), $urandom_range(7),
             $urandom_range(7), $urandom_range(7),
             ($urandom_range(4) == 0), ($urandom_range(4) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
